spi_frame_ctrl: RTL and testbench
=================================

Name: spi_frame_ctrl

Overview:
Receives framed write transactions from the Raspberry Pi over the raw SPI pins. Synchronizes SCLK, MOSI and CS_n into the system clock domain, deserializes the bytes and validates the frame. Buffers the payload and, only after a good frame ends, replays it as a sequence of register writes on a valid/ready bus. It is the sequencer between the Pi link and the on-board register/LED/hex-display datapath.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal length byte 1..MAX_LEN
CMD_WRITE, 8'hA5, the only accepted command byte
SYNC_STAGES, 2, flip-flop stages on each SPI input (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
spi_sclk  in  1  raw SPI clock, asynchronous
spi_mosi  in  1  raw SPI data in, asynchronous
spi_cs_n  in  1  raw chip select, active-low, asynchronous
wr_valid  out  1  write request
wr_ready  in  1  consumer accepts the write when wr_valid && wr_ready
wr_addr  out  8  write address
wr_data  out  8  write data
busy  out  1  1 from frame start until commit ends
frame_ok  out  1  one-cycle pulse when a frame is fully committed
frame_err  out  1  one-cycle pulse when a frame is rejected
err_code  out  3  last error code, held until the next error
frame_count  out  16  number of good frames, wraps at 2^16

Behaviour:
- Single clock, clk. Reset is synchronous and active-high. Reset values: all outputs 0, state IDLE, synchronizers 0, buffer contents don't-care. Reset mid-frame or mid-commit aborts the operation; wr_valid is 0 after that edge.
- SPI mode 0, MSB first. MOSI is sampled on a synchronized SCLK rising edge (edge detected against the previous synchronized value). Bit counter is 3 bits and is cleared on synchronized CS_n falling. When 8 bits are complete, the byte is handed to the FSM in the same cycle.
- Frame format: CMD, ADDR, LEN, DATA[0..LEN-1].
- FSM states: IDLE, CMD, ADDR, LEN, DATA, END, COMMIT.
- IDLE -> CMD on CS fall.
- CMD: byte == CMD_WRITE -> ADDR; otherwise error 1.
- ADDR: latch base address -> LEN.
- LEN: 0 or > MAX_LEN -> error 2; otherwise latch and go to DATA.
- DATA: write byte to buf[idx] and increment idx; after LEN bytes -> END.
- END: CS rise -> COMMIT. Any further complete byte -> error 4 (frame too long).
- CS rise in CMD, ADDR, LEN or DATA -> error 3 (frame too short). Partial bits at CS rise are discarded.
- COMMIT: emits writes i = 0..LEN-1 with wr_addr = (base + i) mod 256 and wr_data = buf[i]. wr_valid rises the cycle after the synchronized CS rise is detected.
- Write handshake: wr_addr and wr_data are stable while wr_valid=1 && !wr_ready. Back-to-back writes are allowed, one per cycle.
- End of commit: the cycle after the last handshake, frame_ok pulses, frame_count increments and the FSM returns to IDLE.
- CS fall during COMMIT: the new frame is ignored entirely and error 5 (busy) is flagged at that CS fall. Commit continues. The FSM stays deaf until the next CS fall seen in IDLE.
- Error handling: discard the buffer, pulse frame_err, load err_code, then wait for CS high and return to IDLE. No writes are issued. Error 5 does not abort the commit in progress.
- busy = (state != IDLE).

Optional Feature:
Macro SPI_FRAME_CHK_EN.
- Defined: a checksum byte follows DATA, equal to the XOR of CMD, ADDR, LEN and all DATA bytes. The FSM adds state CHK between DATA and END. A mismatch gives error 6 (frame rejected). Missing checksum at CS rise gives error 3.
- Undefined: no CHK state, and error code 6 is never produced.

Test Plan:
- Frame A5 10 03 11 22 33, wr_ready=1 -> writes (10,11),(11,22),(12,33) on consecutive cycles; then frame_ok pulses once and frame_count=1.
- Same frame with base ADDR=FE -> addresses FE, FF, 00 (wrap).
- wr_ready held 0 for 5 cycles on the second write -> wr_valid stays 1 and wr_addr/wr_data stay stable; total 3 handshakes.
- Error frames: cmd 5A -> err_code=1; LEN=0 and LEN=17 -> err_code=2; CS rise after 2 data bytes of LEN=3 -> err_code=3; an extra byte -> err_code=4. Each case: no wr_valid, one frame_err pulse.
- New CS fall while committing with wr_ready=0 -> err_code=5; original writes still complete and the new frame produces no writes.
- SPI_FRAME_CHK_EN: A5 10 01 42 with chk F6 -> one write; chk 00 -> err_code=6; reset asserted mid-commit -> wr_valid=0 next cycle and state IDLE.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
`timescale 1ns/1ps
// Receives SPI write frames (CMD, ADDR, LEN, DATA) and replays them as register writes. SPI_FRAME_CHK_EN adds a trailing XOR checksum byte.
// Latency: the first write is presented one cycle after the synchronized CS rise. frame_ok follows the last handshake by one cycle.
// Backpressure: wr_addr and wr_data hold while wr_valid && !wr_ready. One write per cycle while wr_ready is high.
module spi_frame_ctrl #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] CMD_WRITE   = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [15:0] frame_count
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR,
    LEN,
    DATA,
`ifdef SPI_FRAME_CHK_EN
    CHK,
`endif
    END,
    COMMIT,
    ERR
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, cs_fall, cs_rise;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       byte_vld;
  logic [7:0] byte_dat;

  logic [7:0]    base_q;
  logic [AW-1:0] len_m1_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    buf_mem [MAX_LEN];

  logic       err_set, ld_base, ld_len, buf_we, idx_clr, idx_inc, commit_done;
  logic [2:0] err_val;
  logic       len_bad;
`ifdef SPI_FRAME_CHK_EN
  logic [7:0] acc_q;
  logic       acc_clr, acc_upd;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;

  // Mode 0, MSB first; the eighth bit bypasses the shift register so the byte is usable in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else if (cs_fall) begin
      bit_cnt <= 3'd0;
    end else if (sclk_rise && !cs_s) begin
      shreg   <= {shreg[5:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_vld = sclk_rise && !cs_s && (bit_cnt == 3'd7);
  assign byte_dat = {shreg, mosi_s};
  assign len_bad  = (byte_dat == 8'd0) || ({24'd0, byte_dat} > 32'(MAX_LEN));

  always_comb begin
    state_d     = state_q;
    err_set     = 1'b0;
    err_val     = 3'd0;
    ld_base     = 1'b0;
    ld_len      = 1'b0;
    buf_we      = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    commit_done = 1'b0;
`ifdef SPI_FRAME_CHK_EN
    acc_clr     = 1'b0;
    acc_upd     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          idx_clr = 1'b1;
`ifdef SPI_FRAME_CHK_EN
          acc_clr = 1'b1;
`endif
        end
      end
      CMD: begin
        if (cs_rise) begin
          err_set = 1'b1;
          err_val = 3'd3;
          state_d = IDLE;
        end else if (byte_vld) begin
`ifdef SPI_FRAME_CHK_EN
          acc_upd = 1'b1;
`endif
          if (byte_dat == CMD_WRITE) begin
            state_d = ADDR;
          end else begin
            err_set = 1'b1;
            err_val = 3'd1;
            state_d = ERR;
          end
        end
      end
      ADDR: begin
        if (cs_rise) begin
          err_set = 1'b1;
          err_val = 3'd3;
          state_d = IDLE;
        end else if (byte_vld) begin
`ifdef SPI_FRAME_CHK_EN
          acc_upd = 1'b1;
`endif
          ld_base = 1'b1;
          state_d = LEN;
        end
      end
      LEN: begin
        if (cs_rise) begin
          err_set = 1'b1;
          err_val = 3'd3;
          state_d = IDLE;
        end else if (byte_vld) begin
`ifdef SPI_FRAME_CHK_EN
          acc_upd = 1'b1;
`endif
          if (len_bad) begin
            err_set = 1'b1;
            err_val = 3'd2;
            state_d = ERR;
          end else begin
            ld_len  = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          err_set = 1'b1;
          err_val = 3'd3;
          state_d = IDLE;
        end else if (byte_vld) begin
`ifdef SPI_FRAME_CHK_EN
          acc_upd = 1'b1;
`endif
          buf_we = 1'b1;
          if (idx_q == len_m1_q) begin
`ifdef SPI_FRAME_CHK_EN
            state_d = CHK;
`else
            state_d = END;
`endif
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
`ifdef SPI_FRAME_CHK_EN
      CHK: begin
        if (cs_rise) begin
          err_set = 1'b1;
          err_val = 3'd3;
          state_d = IDLE;
        end else if (byte_vld) begin
          if (byte_dat == acc_q) begin
            state_d = END;
          end else begin
            err_set = 1'b1;
            err_val = 3'd6;
            state_d = ERR;
          end
        end
      end
`endif
      END: begin
        if (cs_rise) begin
          state_d = COMMIT;
          idx_clr = 1'b1;
        end else if (byte_vld) begin
          err_set = 1'b1;
          err_val = 3'd4;
          state_d = ERR;
        end
      end
      COMMIT: begin
        // A new frame arriving now is flagged but otherwise ignored; the replay carries on.
        if (cs_fall) begin
          err_set = 1'b1;
          err_val = 3'd5;
        end
        if (wr_ready) begin
          if (idx_q == len_m1_q) begin
            commit_done = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      ERR: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= 8'd0;
      len_m1_q    <= '0;
      idx_q       <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 3'd0;
      frame_count <= 16'd0;
    end else begin
      state_q   <= state_d;
      frame_ok  <= commit_done;
      frame_err <= err_set;
      if (err_set)     err_code    <= err_val;
      if (commit_done) frame_count <= frame_count + 16'd1;
      if (ld_base)     base_q      <= byte_dat;
      if (ld_len)      len_m1_q    <= AW'(byte_dat - 8'd1);
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + AW'(1);
    end
  end

`ifdef SPI_FRAME_CHK_EN
  always_ff @(posedge clk) begin
    if (reset)        acc_q <= 8'd0;
    else if (acc_clr) acc_q <= 8'd0;
    else if (acc_upd) acc_q <= acc_q ^ byte_dat;
  end
`endif

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[idx_q] <= byte_dat;
  end

  assign busy     = (state_q != IDLE);
  assign wr_valid = (state_q == COMMIT);
  assign wr_addr  = wr_valid ? (base_q + 8'(idx_q)) : 8'd0;
  assign wr_data  = wr_valid ? buf_mem[idx_q] : 8'd0;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
`timescale 1ns/1ps
// Bit-banged SPI frames drive spi_frame_ctrl; expected writes are queued from each frame and compared with observed handshakes.
module tb_spi_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  spi_frame_ctrl dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .frame_count(frame_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, ok_cnt = 0, err_cnt = 0, vld_cnt = 0, exp_count = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          obs_cyc[$];
  logic [7:0]  frm[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_valid) vld_cnt++;
    if (wr_valid && wr_ready) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_cyc.push_back(cyc);
    end
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame();
    cs_low();
    foreach (frm[i]) spi_byte(frm[i]);
    cs_high();
  endtask

  task automatic mk(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    logic [7:0] t [7];
    t = '{b0, b1, b2, b3, b4, b5, b6};
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(t[i]);
  endtask

  task automatic add_chk();
`ifdef SPI_FRAME_CHK_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (frm[i]) x ^= frm[i];
    frm.push_back(x);
`endif
  endtask

  // Expected writes derived from the frame: address base+i wrapping at 256, data from the payload.
  task automatic push_expected();
    logic [7:0] a;
    for (int i = 0; i < int'(frm[2]); i++) begin
      a = frm[1] + 8'(i);
      exp_q.push_back({a, frm[3+i]});
    end
    exp_count++;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_idle(output bit to);
    int n;
    n = 0;
    while (busy && n < 400) begin tick(1); n++; end
    to = busy;
    tick(3);
  endtask

  task automatic wait_valid(output bit to);
    int n;
    n = 0;
    while (!wr_valid && n < 200) begin tick(1); n++; end
    to = !wr_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(5);
    vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid: got %0b want 0", wr_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: ok=%0b err=%0b want 0", frame_ok, frame_err); end
    vectors++; if (err_code !== 3'd0) begin miscompares++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    vectors++; if (wr_addr !== 8'd0 || wr_data !== 8'd0) begin miscompares++; $display("FAIL reset_wr_bus: got %h/%h want 00/00", wr_addr, wr_data); end
    reset = 1'b0;
    tick(10);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    bit to; int ok0; logic [15:0] e, o;
    clear_sb(); ok0 = ok_cnt; wr_ready = 1'b1;
    mk(6, 8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00); add_chk();
    push_expected(); send_frame(); wait_idle(to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout: busy still 1"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    vectors++; if (obs_cyc.size() != 3 || obs_cyc[2] - obs_cyc[0] != 2) begin miscompares++; $display("FAIL basic_consecutive: writes not on consecutive cycles"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL basic_write: got %h want %h", o, e); end
    end
    vectors++; if (ok_cnt - ok0 != 1) begin miscompares++; $display("FAIL basic_frame_ok: got %0d pulses want 1", ok_cnt - ok0); end
    vectors++; if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL basic_frame_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_wrap();
    bit to; logic [15:0] e, o;
    clear_sb(); wr_ready = 1'b1;
    mk(6, 8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00); add_chk();
    push_expected(); send_frame(); wait_idle(to);
    vectors++; if (to) begin miscompares++; $display("FAIL wrap_timeout: busy still 1"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wrap_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL wrap_write: got %h want %h", o, e); end
    end
    vectors++; if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL wrap_frame_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_stall();
    bit to; logic [15:0] e, o;
    clear_sb(); wr_ready = 1'b0;
    mk(6, 8'hA5, 8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00); add_chk();
    push_expected(); send_frame(); wait_valid(to);
    vectors++; if (to) begin miscompares++; $display("FAIL stall_no_valid: wr_valid never rose"); end
    wr_ready = 1'b1;
    tick(1);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (wr_valid !== 1'b1 || wr_addr !== 8'h21 || wr_data !== 8'hBB) begin
        miscompares++; $display("FAIL stall_hold: got v=%0b %h/%h want 1 21/BB", wr_valid, wr_addr, wr_data);
      end
    end
    @(posedge clk); #2;
    wr_ready = 1'b1;
    wait_idle(to);
    vectors++; if (to) begin miscompares++; $display("FAIL stall_timeout: busy still 1"); end
    vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL stall_handshakes: got %0d want 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL stall_write: got %h want %h", o, e); end
    end
  endtask

  task automatic test_errors();
    bit to; int e0, v0; logic [2:0] code;
    wr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      code = 3'd0;
      case (k)
        0: begin mk(6, 8'h5A, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00); code = 3'd1; end
        1: begin mk(4, 8'hA5, 8'h10, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00); code = 3'd2; end
        2: begin mk(4, 8'hA5, 8'h10, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00); code = 3'd2; end
        3: begin mk(5, 8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h00, 8'h00); code = 3'd3; end
        default: begin mk(6, 8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00); add_chk(); frm.push_back(8'h44); code = 3'd4; end
      endcase
      e0 = err_cnt; v0 = vld_cnt;
      send_frame(); wait_idle(to);
      vectors++; if (to) begin miscompares++; $display("FAIL err%0d_timeout: busy still 1", k); end
      vectors++; if (err_code !== code) begin miscompares++; $display("FAIL err%0d_code: got %0d want %0d", k, err_code, code); end
      vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL err%0d_pulse: got %0d pulses want 1", k, err_cnt - e0); end
      vectors++; if (vld_cnt != v0) begin miscompares++; $display("FAIL err%0d_no_write: wr_valid seen %0d cycles want 0", k, vld_cnt - v0); end
    end
  endtask

  task automatic test_busy();
    bit to; int e0, ok0; logic [15:0] e, o;
    clear_sb(); wr_ready = 1'b0; ok0 = ok_cnt;
    mk(5, 8'hA5, 8'h30, 8'h02, 8'h55, 8'h66, 8'h00, 8'h00); add_chk();
    push_expected(); send_frame(); wait_valid(to);
    vectors++; if (to) begin miscompares++; $display("FAIL busy_no_valid: wr_valid never rose"); end
    e0 = err_cnt;
    mk(4, 8'hA5, 8'h40, 8'h01, 8'h77, 8'h00, 8'h00, 8'h00); add_chk();
    cs_low();
    tick(4);
    vectors++; if (err_code !== 3'd5) begin miscompares++; $display("FAIL busy_code: got %0d want 5", err_code); end
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL busy_pulse: got %0d pulses want 1", err_cnt - e0); end
    foreach (frm[i]) spi_byte(frm[i]);
    cs_high();
    vectors++; if (wr_valid !== 1'b1 || wr_addr !== 8'h30) begin miscompares++; $display("FAIL busy_commit_held: got v=%0b a=%h want 1 30", wr_valid, wr_addr); end
    wr_ready = 1'b1;
    wait_idle(to);
    tick(20);
    vectors++; if (to) begin miscompares++; $display("FAIL busy_timeout: busy still 1"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL busy_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL busy_write: got %h want %h", o, e); end
    end
    vectors++; if (ok_cnt - ok0 != 1) begin miscompares++; $display("FAIL busy_frame_ok: got %0d want 1", ok_cnt - ok0); end
  endtask

  task automatic test_back_to_back();
    bit to; int ok0; logic [15:0] e, o;
    clear_sb(); wr_ready = 1'b1; ok0 = ok_cnt;
    mk(5, 8'hA5, 8'h60, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00); add_chk();
    push_expected(); send_frame();
    mk(4, 8'hA5, 8'h70, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00); add_chk();
    push_expected(); send_frame(); wait_idle(to);
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout: busy still 1"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_write: got %h want %h", o, e); end
    end
    vectors++; if (ok_cnt - ok0 != 2) begin miscompares++; $display("FAIL b2b_frame_ok: got %0d want 2", ok_cnt - ok0); end
    vectors++; if (frame_count !== 16'(exp_count)) begin miscompares++; $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, exp_count); end
  endtask

`ifdef SPI_FRAME_CHK_EN
  task automatic test_chk();
    bit to; int e0, v0; logic [15:0] e, o;
    clear_sb(); wr_ready = 1'b1;
    mk(5, 8'hA5, 8'h10, 8'h01, 8'h42, 8'hF6, 8'h00, 8'h00);
    push_expected(); send_frame(); wait_idle(to);
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL chk_good_count: got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL chk_good_write: got %h want %h", o, e); end
    end
    e0 = err_cnt; v0 = vld_cnt;
    mk(5, 8'hA5, 8'h10, 8'h01, 8'h42, 8'h00, 8'h00, 8'h00);
    send_frame(); wait_idle(to);
    vectors++; if (err_code !== 3'd6) begin miscompares++; $display("FAIL chk_bad_code: got %0d want 6", err_code); end
    vectors++; if (err_cnt - e0 != 1 || vld_cnt != v0) begin miscompares++; $display("FAIL chk_bad_effect: err pulses %0d valid cycles %0d want 1 0", err_cnt - e0, vld_cnt - v0); end
  endtask
`endif

  task automatic test_reset_mid_commit();
    bit to; int v0;
    clear_sb(); wr_ready = 1'b0;
    mk(5, 8'hA5, 8'h50, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00); add_chk();
    send_frame(); wait_valid(to);
    vectors++; if (to) begin miscompares++; $display("FAIL rst_mid_no_valid: wr_valid never rose"); end
    reset = 1'b1;
    tick(1);
    vectors++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_state: got v=%0b busy=%0b want 0 0", wr_valid, busy); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL rst_mid_count: got %0d want 0", frame_count); end
    reset = 1'b0; exp_count = 0; wr_ready = 1'b1;
    v0 = vld_cnt;
    tick(20);
    vectors++; if (vld_cnt != v0) begin miscompares++; $display("FAIL rst_mid_no_resume: wr_valid seen %0d cycles want 0", vld_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_errors();
    test_busy();
    test_back_to_back();
`ifdef SPI_FRAME_CHK_EN
    test_chk();
`endif
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
